reconfig_scheduler: RTL and testbench
=====================================

// Module: reconfig_scheduler
// PURPOSE
//  Sequences the FPGA internal-reconfiguration interface (cfg_CBSEL/cfg_ENA/cfg_CONFIG/cfg_ERROR).
//  Shares it between NREQ user requesters plus an internal auto-timer, using fixed-priority arbitration.
//  Drives an ARM -> CONFIG-pulse -> WAIT sequence.
//  On error or timeout, retries with the golden image. Sits in the top level between user logic and the cfg_* pins.
// PARAMETERS
//  NREQ          2         number of external requesters
//  IMG_W         2         image-select width (cfg_CBSEL)
//  GOLDEN_IMAGE  2'b00     fallback image index
//  ARM_CYCLES    4         cycles cfg_ENA/cfg_CBSEL are stable before cfg_CONFIG rises (>=1)
//  PULSE_CYCLES  16        cfg_CONFIG high time (>=1)
//  WAIT_CYCLES   1024      cycles allowed for reconfiguration to take effect after the pulse
//  AUTO_CYCLES   24'h1AB400 auto-timer period (~7 s)
//  AUTO_IMAGE    2'b01     image requested by the auto-timer
//  MAX_RETRY     1         golden-image retries after a failure
// PORTS
//  clk           in   1            system clock
//  rst           in   1            asynchronous reset, active-high
//  req           in   NREQ         request per requester; held high until granted
//  req_image     in   NREQ*IMG_W   image index per requester; slice i belongs to req[i]
//  auto_en       in   1            enables the auto-timer
//  cfg_ERROR     in   1            reconfiguration error from the device (asynchronous)
//  cfg_CBSEL     out  IMG_W        image select to the device
//  cfg_ENA       out  1            reconfiguration enable
//  cfg_CONFIG    out  1            reconfiguration trigger
//  grant         out  NREQ         one-hot, one-cycle grant
//  busy          out  1            high when state != IDLE
//  fail          out  1            sticky failure flag
// BEHAVIOUR
//  Reset (asynchronous, every output registered):
//   - cfg_CBSEL=GOLDEN_IMAGE; cfg_ENA=0; cfg_CONFIG=0; grant=0; busy=0; fail=0
//   - state=IDLE; auto counter=0; retry=0
//   - Reset mid-sequence drops cfg_CONFIG/cfg_ENA immediately.
//  cfg_ERROR passes through a 2-flop synchroniser: 2-cycle latency to err_s.
//  Auto-timer:
//   - 24-bit counter runs while auto_en=1 and there is no auto_pend; auto_en=0 clears the counter and auto_pend.
//   - At AUTO_CYCLES-1 the counter sets auto_pend and clears itself.
//   - auto_pend is the lowest-priority request; it clears when auto_pend is granted.
//  States: IDLE, ARM, PULSE, WAIT, ERR.
//  IDLE:
//   - Fixed priority: req[0] highest, auto_pend lowest.
//   - If any request is present at edge N, then at edge N+1: grant[i]=1 (auto: no grant bit),
//     image latched, cfg_CBSEL=image, cfg_ENA=1, retry=0, fail=0, state -> ARM.
//   - Requests outside IDLE are ignored, not queued.
//  ARM: hold for ARM_CYCLES, then -> PULSE; cfg_CONFIG rises at edge N+1+ARM_CYCLES.
//  PULSE: cfg_CONFIG=1 for exactly PULSE_CYCLES, then -> WAIT with cfg_CONFIG=0.
//  WAIT:
//   - cfg_ENA stays 1.
//   - err_s=1 -> ERR.
//   - Counter reaches WAIT_CYCLES -> ERR (the device did not reload).
//   - If err_s and the timeout occur in the same cycle, the result is ERR (identical).
//  ERR (1 cycle):
//   - If retry<MAX_RETRY and image!=GOLDEN_IMAGE: retry++, image=GOLDEN_IMAGE, cfg_CBSEL updated, -> ARM.
//   - Otherwise: fail=1, cfg_ENA=0, cfg_CBSEL=GOLDEN_IMAGE, -> IDLE.
//  cfg_CBSEL changes only on the IDLE->ARM and ERR->ARM transitions; it is stable throughout ARM/PULSE/WAIT.
//  Counters saturate; none wraps. Phase counters are sized $clog2 of their parameter + 1.
// STRUCTURE
//  reconfig_pkg: state encoding localparams, IMG_W, GOLDEN_IMAGE.
//  Sub-module reconfig_prio_arb: combinational fixed-priority one-hot picker (NREQ+1 inputs).
//  Phase timer: one shared down-counter, reloaded on each state entry.
// TESTING (bench params: ARM=4, PULSE=16, WAIT=32, AUTO=100)
//  1. req=01, image1=2'b10 -> grant=01 at +1; CBSEL=10 and ENA=1 at +1; CONFIG high cycles +5..+20.
//  2. req=11 in the same cycle -> only grant=01; req[1] granted only after the sequence returns to IDLE.
//  3. cfg_ERROR pulses 3 cycles in WAIT, image 2'b10 -> ERR, then ARM with CBSEL=00;
//     second error -> fail=1, ENA=0, IDLE.
//  4. No cfg_ERROR, image=GOLDEN -> WAIT times out at 32 -> fail=1 immediately (no retry).
//  5. auto_en=1, no req -> sequence starts 100 cycles later with CBSEL=AUTO_IMAGE.
//     If req[1] is asserted in the same cycle, req[1] wins.
//  6. rst asserted during PULSE -> CONFIG=0, ENA=0, CBSEL=00, busy=0 without waiting for a clock.

Source files
------------

// File: rtl/reconfig_pkg.sv
// Shared types and constants for the internal-reconfiguration scheduler.
package reconfig_pkg;

    localparam int                IMG_W        = 2;
    localparam logic [IMG_W-1:0]  GOLDEN_IMAGE = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_PULSE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reconfig_prio_arb.sv
// Combinational fixed-priority one-hot picker; bit 0 has the highest priority.
module reconfig_prio_arb #(
    parameter int N = 3
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    // NOTE: assign a default before the loop so no path leaves gnt_o unassigned (no latch).
    always_comb begin
        gnt_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reconfig_scheduler.sv
// Arbitrates user/auto-timer reconfiguration requests and drives the ARM -> CONFIG pulse -> WAIT
// sequence on the cfg_* pins, falling back once to the golden image on error or timeout.
module reconfig_scheduler
    import reconfig_pkg::*;
#(
    parameter int               NREQ         = 2,
    parameter int               ARM_CYCLES   = 4,
    parameter int               PULSE_CYCLES = 16,
    parameter int               WAIT_CYCLES  = 1024,
    parameter logic [23:0]      AUTO_CYCLES  = 24'h1AB400,
    parameter logic [IMG_W-1:0] AUTO_IMAGE   = 2'b01,
    parameter int               MAX_RETRY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*IMG_W-1:0] req_image,
    input  logic                  auto_en,
    input  logic                  cfg_ERROR,
    output logic [IMG_W-1:0]      cfg_CBSEL,
    output logic                  cfg_ENA,
    output logic                  cfg_CONFIG,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  fail
);

    localparam int TMR_W   = $clog2(max_of(max_of(ARM_CYCLES, PULSE_CYCLES), WAIT_CYCLES)) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRY) + 1;

    localparam logic [TMR_W-1:0]   ARM_LOAD   = TMR_W'(ARM_CYCLES - 1);
    localparam logic [TMR_W-1:0]   PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   WAIT_LOAD  = TMR_W'(WAIT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    state_e             state_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [IMG_W-1:0]   image_q;
    logic [RETRY_W-1:0] retry_q;
    logic               err_meta_q, err_s_q;
    logic [23:0]        auto_cnt_q, auto_cnt_d;
    logic               auto_pend_q, auto_pend_d;
    logic [NREQ:0]      pick;
    logic [IMG_W-1:0]   pick_image;
    logic               auto_take;

    reconfig_prio_arb #(.N(NREQ + 1)) u_arb (
        .req_i (({auto_pend_q, req})),
        .gnt_o (pick)
    );

    always_comb begin
        pick_image = AUTO_IMAGE;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_image = req_image[i*IMG_W +: IMG_W];
        end
    end

    assign auto_take = (state_q == ST_IDLE) && pick[NREQ];

    // Auto-timer: stops counting while a request is pending, restarts after it is granted.
    always_comb begin
        auto_cnt_d  = auto_cnt_q;
        auto_pend_d = auto_pend_q;
        if (!auto_en) begin
            auto_cnt_d  = '0;
            auto_pend_d = 1'b0;
        end else if (auto_take) begin
            auto_pend_d = 1'b0;
        end else if (!auto_pend_q) begin
            if (auto_cnt_q == AUTO_CYCLES - 24'd1) begin
                auto_cnt_d  = '0;
                auto_pend_d = 1'b1;
            end else begin
                auto_cnt_d = auto_cnt_q + 24'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_meta_q  <= 1'b0;
            err_s_q     <= 1'b0;
            auto_cnt_q  <= '0;
            auto_pend_q <= 1'b0;
        end else begin
            err_meta_q  <= cfg_ERROR;
            err_s_q     <= err_meta_q;
            auto_cnt_q  <= auto_cnt_d;
            auto_pend_q <= auto_pend_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            image_q    <= GOLDEN_IMAGE;
            retry_q    <= '0;
            cfg_CBSEL  <= GOLDEN_IMAGE;
            cfg_ENA    <= 1'b0;
            cfg_CONFIG <= 1'b0;
            grant      <= '0;
            busy       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            grant <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|pick) begin
                        grant     <= pick[NREQ-1:0];
                        image_q   <= pick_image;
                        cfg_CBSEL <= pick_image;
                        cfg_ENA   <= 1'b1;
                        retry_q   <= '0;
                        fail      <= 1'b0;
                        busy      <= 1'b1;
                        tmr_q     <= ARM_LOAD;
                        state_q   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (tmr_q == '0) begin
                        cfg_CONFIG <= 1'b1;
                        tmr_q      <= PULSE_LOAD;
                        state_q    <= ST_PULSE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (tmr_q == '0) begin
                        cfg_CONFIG <= 1'b0;
                        tmr_q      <= WAIT_LOAD;
                        state_q    <= ST_WAIT;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                ST_WAIT: begin
                    // An error and a timeout in the same cycle both land in ERR.
                    if (err_s_q || (tmr_q == '0)) begin
                        state_q <= ST_ERR;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                ST_ERR: begin
                    if ((retry_q < RETRY_MAX) && (image_q != GOLDEN_IMAGE)) begin
                        retry_q   <= retry_q + 1'b1;
                        image_q   <= GOLDEN_IMAGE;
                        cfg_CBSEL <= GOLDEN_IMAGE;
                        tmr_q     <= ARM_LOAD;
                        state_q   <= ST_ARM;
                    end else begin
                        fail      <= 1'b1;
                        cfg_ENA   <= 1'b0;
                        cfg_CBSEL <= GOLDEN_IMAGE;
                        busy      <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    cfg_ENA    <= 1'b0;
                    cfg_CONFIG <= 1'b0;
                    busy       <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reconfig_scheduler.sv
// Directed bench for reconfig_scheduler with short phase/auto periods; expectations hand-derived.
module tb_reconfig_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [3:0] req_image = '0;
    logic       auto_en = 1'b0;
    logic       cfg_ERROR = 1'b0;
    logic [1:0] cfg_CBSEL;
    logic       cfg_ENA, cfg_CONFIG;
    logic [1:0] grant;
    logic       busy, fail;

    int n_cmp = 0;
    int n_bad = 0;
    int rel   = 0;

    reconfig_scheduler #(
        .NREQ(2), .ARM_CYCLES(4), .PULSE_CYCLES(16), .WAIT_CYCLES(32),
        .AUTO_CYCLES(24'd100), .AUTO_IMAGE(2'b01), .MAX_RETRY(1)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_image(req_image),
        .auto_en(auto_en), .cfg_ERROR(cfg_ERROR),
        .cfg_CBSEL(cfg_CBSEL), .cfg_ENA(cfg_ENA), .cfg_CONFIG(cfg_CONFIG),
        .grant(grant), .busy(busy), .fail(fail)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        rel++;
    endtask

    task automatic to_edge(input int k);
        while (rel < k) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_image = '0; auto_en = 1'b0; cfg_ERROR = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rel = 0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if ({cfg_CBSEL, cfg_ENA, cfg_CONFIG} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_cfg: got %b want 0000", {cfg_CBSEL, cfg_ENA, cfg_CONFIG}); end
        n_cmp++; if ({grant, busy, fail} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_status: got %b want 0000", {grant, busy, fail}); end
        do_reset();
        n_cmp++; if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        int first_hi = -1;
        int n_hi = 0;
        do_reset();
        req_image = 4'b00_10; req = 2'b01; rel = 0;
        tick();
        req = 2'b00;
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", grant); end
        n_cmp++; if ({cfg_CBSEL, cfg_ENA, cfg_CONFIG, busy} !== 5'b10101) begin
            n_bad++; $display("FAIL single_arm: got %b want 10101", {cfg_CBSEL, cfg_ENA, cfg_CONFIG, busy}); end
        tick();
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL single_grant_1cyc: got %b want 00", grant); end
        while (rel < 30) begin
            tick();
            if (cfg_CONFIG) begin
                n_hi++;
                if (first_hi < 0) first_hi = rel;
            end
        end
        n_cmp++; if (first_hi !== 5) begin n_bad++; $display("FAIL single_cfg_rise: got %0d want 5", first_hi); end
        n_cmp++; if (n_hi !== 16) begin n_bad++; $display("FAIL single_cfg_width: got %0d want 16", n_hi); end
        n_cmp++; if ({cfg_CBSEL, cfg_ENA} !== 3'b101) begin
            n_bad++; $display("FAIL single_wait_hold: got %b want 101", {cfg_CBSEL, cfg_ENA}); end
    endtask

    task automatic test_back_to_back();
        int early = 0;
        do_reset();
        req_image = 4'b11_01; req = 2'b11; rel = 0;
        tick();
        req = 2'b10;
        n_cmp++; if ({grant, cfg_CBSEL} !== 4'b01_01) begin
            n_bad++; $display("FAIL b2b_first: got %b want 0101", {grant, cfg_CBSEL}); end
        for (int i = 0; i < 300; i++) begin
            tick();
            if (grant[1]) early++;
            if (!busy) break;
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_timeout: busy got %b want 0", busy); end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL b2b_no_queue: got %0d grants want 0", early); end
        n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL b2b_fail: got %b want 1", fail); end
        tick();
        req = 2'b00;
        n_cmp++; if ({grant, cfg_CBSEL, busy, fail} !== 6'b10_11_1_0) begin
            n_bad++; $display("FAIL b2b_second: got %b want 101110", {grant, cfg_CBSEL, busy, fail}); end
    endtask

    task automatic test_error_retry();
        do_reset();
        req_image = 4'b00_10; req = 2'b01; rel = 0;
        tick();
        req = 2'b00;
        to_edge(21);
        cfg_ERROR = 1'b1;
        to_edge(24);
        cfg_ERROR = 1'b0;
        n_cmp++; if ({busy, cfg_CBSEL, cfg_ENA} !== 4'b1101) begin
            n_bad++; $display("FAIL err_state: got %b want 1101", {busy, cfg_CBSEL, cfg_ENA}); end
        tick();
        n_cmp++; if ({busy, cfg_CBSEL, cfg_ENA, fail} !== 5'b10010) begin
            n_bad++; $display("FAIL err_retry_arm: got %b want 10010", {busy, cfg_CBSEL, cfg_ENA, fail}); end
        to_edge(28);
        n_cmp++; if (cfg_CONFIG !== 1'b0) begin n_bad++; $display("FAIL err_retry_arm_len: got %b want 0", cfg_CONFIG); end
        tick();
        n_cmp++; if (cfg_CONFIG !== 1'b1) begin n_bad++; $display("FAIL err_retry_pulse: got %b want 1", cfg_CONFIG); end
        to_edge(45);
        cfg_ERROR = 1'b1;
        to_edge(48);
        cfg_ERROR = 1'b0;
        n_cmp++; if ({busy, fail} !== 2'b10) begin n_bad++; $display("FAIL err2_state: got %b want 10", {busy, fail}); end
        tick();
        n_cmp++; if ({busy, fail, cfg_ENA, cfg_CONFIG, cfg_CBSEL} !== 6'b010000) begin
            n_bad++; $display("FAIL err2_fail: got %b want 010000", {busy, fail, cfg_ENA, cfg_CONFIG, cfg_CBSEL}); end
    endtask

    task automatic test_golden_timeout();
        do_reset();
        req_image = 4'b00_00; req = 2'b01; rel = 0;
        tick();
        req = 2'b00;
        to_edge(53);
        n_cmp++; if ({busy, fail, cfg_ENA} !== 3'b101) begin
            n_bad++; $display("FAIL gold_err: got %b want 101", {busy, fail, cfg_ENA}); end
        tick();
        n_cmp++; if ({busy, fail, cfg_ENA, cfg_CBSEL} !== 5'b01000) begin
            n_bad++; $display("FAIL gold_fail: got %b want 01000", {busy, fail, cfg_ENA, cfg_CBSEL}); end
    endtask

    task automatic test_auto();
        do_reset();
        auto_en = 1'b1; rel = 0;
        to_edge(100);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL auto_early: busy got %b want 0", busy); end
        tick();
        n_cmp++; if ({busy, cfg_CBSEL, cfg_ENA, grant} !== 6'b1_01_1_00) begin
            n_bad++; $display("FAIL auto_start: got %b want 101100", {busy, cfg_CBSEL, cfg_ENA, grant}); end
        do_reset();
        auto_en = 1'b1; rel = 0;
        to_edge(100);
        req_image = 4'b11_00; req = 2'b10;
        tick();
        req = 2'b00; auto_en = 1'b0;
        n_cmp++; if ({grant, cfg_CBSEL, busy} !== 5'b10_11_1) begin
            n_bad++; $display("FAIL auto_vs_req: got %b want 10111", {grant, cfg_CBSEL, busy}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_image = 4'b00_10; req = 2'b01; rel = 0;
        tick();
        req = 2'b00;
        to_edge(10);
        n_cmp++; if (cfg_CONFIG !== 1'b1) begin n_bad++; $display("FAIL rmid_pulse: got %b want 1", cfg_CONFIG); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({cfg_CONFIG, cfg_ENA, cfg_CBSEL, busy} !== 5'b00000) begin
            n_bad++; $display("FAIL rmid_async: got %b want 00000", {cfg_CONFIG, cfg_ENA, cfg_CBSEL, busy}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_error_retry();
        test_golden_timeout();
        test_auto();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
